rf_wr_arb: RTL and testbench
============================

RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set register-file data width.
REQ-002 Parameter ADDRESS_WIDTH, default 4, SHALL set register address width; register count = 2**ADDRESS_WIDTH.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Ports alu_rfa_req, mul_rfa_req, shf_rfa_req  input  1 each  SHALL be write requests from the ALU, multiplier and shifter.
REQ-006 Ports alu_rfa_add, mul_rfa_add, shf_rfa_add  input  ADDRESS_WIDTH each  SHALL be the destination register of each requester.
REQ-007 Ports alu_rfa_dt, mul_rfa_dt, shf_rfa_dt  input  DATA_WIDTH each  SHALL be the write data of each requester.
REQ-008 Ports rfa_alu_gnt, rfa_mul_gnt, rfa_shf_gnt  output  1 each  SHALL be one-cycle grants.
REQ-009 Port ps_rfa_rsv_En  input  1  SHALL request reservation (mark busy) of a destination register at issue.
REQ-010 Port ps_rfa_rsv_add  input  ADDRESS_WIDTH  SHALL be the register to reserve.
REQ-011 Port xb_rf_w_En  output  1  SHALL drive the register-file write enable.
REQ-012 Port ps_xb_wadd  output  ADDRESS_WIDTH  SHALL drive the register-file write address.
REQ-013 Port xb_rf_dt  output  DATA_WIDTH  SHALL drive the register-file write data.
REQ-014 Port rfa_ps_busy  output  2**ADDRESS_WIDTH  SHALL flag, per register, a reserved-but-uncommitted write.

Function
REQ-015 Arbitration SHALL be round-robin over order ALU(0), MUL(1), SHF(2), starting search at pointer rr_ptr.
REQ-016 In any cycle with at least one req high, exactly one grant SHALL assert, combinationally, for the first requesting index at or after rr_ptr (mod 3).
REQ-017 No grant SHALL assert when all req are low; rr_ptr SHALL then hold.
REQ-018 On a grant to index k, rr_ptr SHALL become (k+1) mod 3 at the next edge.
REQ-019 A requester SHALL hold req, add and dt stable until its grant cycle; the sampled values in the grant cycle SHALL be used.
REQ-020 On grant, xb_rf_w_En, ps_xb_wadd, xb_rf_dt SHALL be registered: write appears exactly 1 cycle after the grant cycle, for exactly 1 cycle.
REQ-021 xb_rf_w_En SHALL be 0 in any cycle not following a grant; ps_xb_wadd and xb_rf_dt SHALL hold their last values when not writing.
REQ-022 A requester holding req high after its grant SHALL be treated as a new request (back-to-back allowed, subject to round-robin).
REQ-023 rfa_ps_busy[n] SHALL set on the edge where ps_rfa_rsv_En=1 and ps_rfa_rsv_add=n.
REQ-024 rfa_ps_busy[n] SHALL clear on the edge where xb_rf_w_En=1 and ps_xb_wadd=n (commit).
REQ-025 Simultaneous set and clear of the same n SHALL leave busy[n]=1 (new reservation wins).
REQ-026 Reservation of an already-busy register SHALL leave it busy; no count is kept.
REQ-027 Commit to a non-busy register SHALL write normally and leave busy[n]=0.

Reset
REQ-028 While reset=1 at an edge: rr_ptr=0, xb_rf_w_En=0, ps_xb_wadd=0, xb_rf_dt=0, rfa_ps_busy=all 0.
REQ-029 Grants SHALL be forced 0 while reset=1; a grant pending in the cycle reset asserts SHALL be discarded (no write after reset).
REQ-030 Reservations presented while reset=1 SHALL be ignored.

Structure
REQ-031 Requester indices (ALU=0, MUL=1, SHF=2), requester count 3, and default widths SHALL live in a shared package.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arb3 (req[2:0], ptr -> gnt one-hot); scoreboard and output register stay in rf_wr_arb.

Verification
REQ-033 After reset, ALU req add=3 dt=16'hA5A5 alone -> rfa_alu_gnt same cycle; next cycle xb_rf_w_En=1, ps_xb_wadd=3, xb_rf_dt=16'hA5A5.
REQ-034 All three req held high 6 cycles from reset -> grants ALU,MUL,SHF,ALU,MUL,SHF; writes follow one cycle later in same order.
REQ-035 rr_ptr=1 (after ALU grant), only ALU and SHF requesting -> SHF granted first, then ALU.
REQ-036 Reserve reg 5, commit to 5 two cycles later -> busy[5]=1 then 0; reserve 7 in same cycle as commit to 7 -> busy[7] stays 1.
REQ-037 Assert reset in a grant cycle (MUL, add=9) -> no write next cycle, busy=0, rr_ptr=0, next arbitration starts at ALU.

Source files
------------

// File: rtl/rf_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_arb_pkg
// Brief    : Shared requester indices, counts and default widths for rf_wr_arb.
// Revision : 1.0
// ============================================================================
package rf_wr_arb_pkg;

    localparam int c_NUM_REQ           = 3;
    localparam int c_IDX_ALU           = 0;
    localparam int c_IDX_MUL           = 1;
    localparam int c_IDX_SHF           = 2;
    localparam int c_DEF_DATA_WIDTH    = 16;
    localparam int c_DEF_ADDRESS_WIDTH = 4;

    // Round-robin successor over the three requester slots.
    function automatic logic [1:0] f_next_ptr(input logic [1:0] idx);
        return (idx == 2'(c_NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wr_arb_rr_arb3.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb3
// Brief    : Three-way round-robin arbiter; one-hot grant to the first
//            requester at or after ptr (mod 3).
// Revision : 1.0
// ============================================================================
module rr_arb3
    import rf_wr_arb_pkg::*;
(
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [1:0]           ptr,
    output logic [c_NUM_REQ-1:0] gnt
);

    logic [1:0] w_idx0;
    logic [1:0] w_idx1;
    logic [1:0] w_idx2;

    assign w_idx0 = ptr;
    assign w_idx1 = f_next_ptr(ptr);
    assign w_idx2 = f_next_ptr(w_idx1);

    always_comb begin
        gnt = '0;
        if (req[w_idx0]) begin
            gnt[w_idx0] = 1'b1;
        end else if (req[w_idx1]) begin
            gnt[w_idx1] = 1'b1;
        end else if (req[w_idx2]) begin
            gnt[w_idx2] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rf_wr_arb
// Brief    : Register-file write-port arbiter for ALU/MUL/SHF with a
//            per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module rf_wr_arb
    import rf_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = c_DEF_ADDRESS_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_rfa_req,
    input  logic                          mul_rfa_req,
    input  logic                          shf_rfa_req,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rfa_add,
    input  logic [ADDRESS_WIDTH-1:0]      mul_rfa_add,
    input  logic [ADDRESS_WIDTH-1:0]      shf_rfa_add,
    input  logic [DATA_WIDTH-1:0]         alu_rfa_dt,
    input  logic [DATA_WIDTH-1:0]         mul_rfa_dt,
    input  logic [DATA_WIDTH-1:0]         shf_rfa_dt,
    output logic                          rfa_alu_gnt,
    output logic                          rfa_mul_gnt,
    output logic                          rfa_shf_gnt,
    input  logic                          ps_rfa_rsv_En,
    input  logic [ADDRESS_WIDTH-1:0]      ps_rfa_rsv_add,
    output logic                          xb_rf_w_En,
    output logic [ADDRESS_WIDTH-1:0]      ps_xb_wadd,
    output logic [DATA_WIDTH-1:0]         xb_rf_dt,
    output logic [2**ADDRESS_WIDTH-1:0]   rfa_ps_busy
);

    localparam int c_NUM_REGS = 2**ADDRESS_WIDTH;

    logic [c_NUM_REQ-1:0]     w_req;
    logic [c_NUM_REQ-1:0]     w_arb_gnt;
    logic [c_NUM_REQ-1:0]     w_gnt;
    logic [1:0]               w_gnt_idx;
    logic [ADDRESS_WIDTH-1:0] w_sel_add;
    logic [DATA_WIDTH-1:0]    w_sel_dt;
    logic [c_NUM_REGS-1:0]    w_set;
    logic [c_NUM_REGS-1:0]    w_clr;

    logic [1:0]               r_rr_ptr;
    logic                     r_wen;
    logic [ADDRESS_WIDTH-1:0] r_wadd;
    logic [DATA_WIDTH-1:0]    r_wdt;
    logic [c_NUM_REGS-1:0]    r_busy;

    assign w_req[c_IDX_ALU] = alu_rfa_req;
    assign w_req[c_IDX_MUL] = mul_rfa_req;
    assign w_req[c_IDX_SHF] = shf_rfa_req;

    rr_arb3 u_rr_arb3 (
        .req (w_req),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt)
    );

    // Masking here kills a grant in the reset cycle, so no write follows it.
    assign w_gnt = reset ? '0 : w_arb_gnt;

    assign rfa_alu_gnt = w_gnt[c_IDX_ALU];
    assign rfa_mul_gnt = w_gnt[c_IDX_MUL];
    assign rfa_shf_gnt = w_gnt[c_IDX_SHF];

    always_comb begin
        w_gnt_idx = 2'(c_IDX_ALU);
        w_sel_add = alu_rfa_add;
        w_sel_dt  = alu_rfa_dt;
        if (w_gnt[c_IDX_MUL]) begin
            w_gnt_idx = 2'(c_IDX_MUL);
            w_sel_add = mul_rfa_add;
            w_sel_dt  = mul_rfa_dt;
        end else if (w_gnt[c_IDX_SHF]) begin
            w_gnt_idx = 2'(c_IDX_SHF);
            w_sel_add = shf_rfa_add;
            w_sel_dt  = shf_rfa_dt;
        end
    end

    // Set is OR-ed after clear so a same-edge reservation wins over a commit.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (ps_rfa_rsv_En) begin
            w_set[ps_rfa_rsv_add] = 1'b1;
        end
        if (r_wen) begin
            w_clr[r_wadd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
            r_wen    <= 1'b0;
            r_wadd   <= '0;
            r_wdt    <= '0;
            r_busy   <= '0;
        end else begin
            r_wen  <= |w_gnt;
            r_busy <= (r_busy & ~w_clr) | w_set;
            if (|w_gnt) begin
                r_rr_ptr <= f_next_ptr(w_gnt_idx);
                r_wadd   <= w_sel_add;
                r_wdt    <= w_sel_dt;
            end
        end
    end

    assign xb_rf_w_En  = r_wen;
    assign ps_xb_wadd  = r_wadd;
    assign xb_rf_dt    = r_wdt;
    assign rfa_ps_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wr_arb
// Brief    : Scoreboard bench for rf_wr_arb: directed scenarios plus random
//            traffic against a behavioural arbitration/scoreboard model.
// Revision : 1.0
// ============================================================================
module tb_rf_wr_arb;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2**AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          alu_req, mul_req, shf_req;
    logic [AW-1:0] alu_add, mul_add, shf_add;
    logic [DW-1:0] alu_dt, mul_dt, shf_dt;
    logic          rsv_en;
    logic [AW-1:0] rsv_add;
    logic          alu_gnt, mul_gnt, shf_gnt;
    logic          xb_rf_w_En;
    logic [AW-1:0] ps_xb_wadd;
    logic [DW-1:0] xb_rf_dt;
    logic [NR-1:0] rfa_ps_busy;
    logic [2:0]    dut_gnt;

    assign dut_gnt = {shf_gnt, mul_gnt, alu_gnt};

    rf_wr_arb #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_rfa_req    (alu_req),
        .mul_rfa_req    (mul_req),
        .shf_rfa_req    (shf_req),
        .alu_rfa_add    (alu_add),
        .mul_rfa_add    (mul_add),
        .shf_rfa_add    (shf_add),
        .alu_rfa_dt     (alu_dt),
        .mul_rfa_dt     (mul_dt),
        .shf_rfa_dt     (shf_dt),
        .rfa_alu_gnt    (alu_gnt),
        .rfa_mul_gnt    (mul_gnt),
        .rfa_shf_gnt    (shf_gnt),
        .ps_rfa_rsv_En  (rsv_en),
        .ps_rfa_rsv_add (rsv_add),
        .xb_rf_w_En     (xb_rf_w_En),
        .ps_xb_wadd     (ps_xb_wadd),
        .xb_rf_dt       (xb_rf_dt),
        .rfa_ps_busy    (rfa_ps_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: pointer, busy set, and queue of expected writes.
    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exq[$];
    int            m_ptr;
    logic [NR-1:0] m_busy;
    bit            m_wen;
    logic [AW-1:0] m_wadd;

    task automatic step(input bit rst, input bit [2:0] r,
                        input logic [2:0][AW-1:0] a, input logic [2:0][DW-1:0] d,
                        input bit ren, input logic [AW-1:0] radd, output int k);
        logic [2:0] eg;
        @(posedge clk);
        #1;
        reset   = rst;
        alu_req = r[0];  mul_req = r[1];  shf_req = r[2];
        alu_add = a[0];  mul_add = a[1];  shf_add = a[2];
        alu_dt  = d[0];  mul_dt  = d[1];  shf_dt  = d[2];
        rsv_en  = ren;
        rsv_add = radd;
        @(negedge clk);
        k = -1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (k < 0 && r[(m_ptr + i) % 3]) k = (m_ptr + i) % 3;
            end
        end
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        check("grant", 32'(dut_gnt), 32'(eg));
        check("busy", 32'(rfa_ps_busy), 32'(m_busy));
        if (rst) begin
            m_ptr  = 0;
            m_busy = '0;
            m_wen  = 1'b0;
        end else begin
            if (m_wen) m_busy[m_wadd] = 1'b0;
            if (ren)   m_busy[radd]   = 1'b1;
            m_wen = (k >= 0);
            if (k >= 0) begin
                exq.push_back('{cyc + 1, a[k], d[k]});
                m_wadd = a[k];
                m_ptr  = (k + 1) % 3;
            end
        end
    endtask

    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0, '0, 1'b0, '0, k);
    endtask

    // Write-port monitor: pops the scoreboard whenever a write is presented.
    logic          rst_seen;
    bit            mon_en = 1'b0;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    wr_t           mon_e;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen === 1'b1) begin
                last_a = '0;
                last_d = '0;
            end
            if (xb_rf_w_En === 1'b1) begin
                if (exq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_write: got addr %h data %h, expected no write (cycle %0d)",
                             ps_xb_wadd, xb_rf_dt, cyc);
                end else begin
                    mon_e = exq.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(mon_e.due));
                    check("wr_addr", 32'(ps_xb_wadd), 32'(mon_e.a));
                    check("wr_data", 32'(xb_rf_dt), 32'(mon_e.d));
                    last_a = mon_e.a;
                    last_d = mon_e.d;
                end
            end else begin
                check("wr_en_low", 32'(xb_rf_w_En), 32'(0));
                check("hold_addr", 32'(ps_xb_wadd), 32'(last_a));
                check("hold_data", 32'(xb_rf_dt), 32'(last_d));
                if (exq.size() > 0 && exq[0].due <= cyc) begin
                    mon_e = exq.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_write: got no write, expected addr %h data %h (cycle %0d)",
                             mon_e.a, mon_e.d, cyc);
                end
            end
        end
    end

    initial begin
        int                 k;
        int                 gl;
        bit [2:0]           pr;
        logic [2:0][AW-1:0] a;
        logic [2:0][DW-1:0] d;
        logic [2:0]         ord [6];
        bit                 rst;
        bit                 ren;
        logic [AW-1:0]      radd;

        reset = 1'b1;
        {alu_req, mul_req, shf_req, rsv_en} = '0;
        {alu_add, mul_add, shf_add, rsv_add} = '0;
        {alu_dt, mul_dt, shf_dt} = '0;
        repeat (2) @(posedge clk);
        m_ptr  = 0;
        m_busy = '0;
        m_wen  = 1'b0;
        m_wadd = '0;
        mon_en = 1'b1;

        // Single ALU write right after reset.
        a = '0;
        d = '0;
        a[0] = 4'd3;
        d[0] = 16'hA5A5;
        step(1'b0, 3'b001, a, d, 1'b0, '0, k);
        check("alu_gnt_same_cycle", 32'(dut_gnt), 32'(3'b001));
        idle(1);
        check("alu_write_en", 32'(xb_rf_w_En), 32'(1));
        check("alu_write_addr", 32'(ps_xb_wadd), 32'(3));
        check("alu_write_data", 32'(xb_rf_dt), 32'(16'hA5A5));

        // All three requesting from reset: strict rotation.
        step(1'b1, 3'b000, '0, '0, 1'b0, '0, k);
        ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) begin
                a[j] = AW'(i * 3 + j);
                d[j] = DW'($urandom);
            end
            step(1'b0, 3'b111, a, d, 1'b0, '0, k);
            check("rotation_order", 32'(dut_gnt), 32'(ord[i]));
        end
        idle(1);

        // Pointer at MUL with only ALU and SHF requesting.
        step(1'b1, 3'b000, '0, '0, 1'b0, '0, k);
        step(1'b0, 3'b001, a, d, 1'b0, '0, k);
        step(1'b0, 3'b101, a, d, 1'b0, '0, k);
        check("skip_to_shf", 32'(dut_gnt), 32'(3'b100));
        step(1'b0, 3'b001, a, d, 1'b0, '0, k);
        check("then_alu", 32'(dut_gnt), 32'(3'b001));
        idle(1);

        // Reserve/commit sequencing, including same-edge reserve and commit.
        step(1'b1, 3'b000, '0, '0, 1'b0, '0, k);
        step(1'b0, 3'b000, '0, '0, 1'b1, 4'd5, k);
        a[0] = 4'd5;
        step(1'b0, 3'b001, a, d, 1'b0, '0, k);
        check("busy5_set", 32'(rfa_ps_busy[5]), 32'(1));
        idle(1);
        check("busy5_during_commit", 32'(rfa_ps_busy[5]), 32'(1));
        idle(1);
        check("busy5_cleared", 32'(rfa_ps_busy[5]), 32'(0));
        step(1'b0, 3'b000, '0, '0, 1'b1, 4'd7, k);
        a[0] = 4'd7;
        step(1'b0, 3'b001, a, d, 1'b0, '0, k);
        step(1'b0, 3'b000, '0, '0, 1'b1, 4'd7, k);
        idle(1);
        check("busy7_rsv_wins", 32'(rfa_ps_busy[7]), 32'(1));
        a[0] = 4'd9;
        step(1'b0, 3'b000, '0, '0, 1'b0, '0, k);
        step(1'b0, 3'b000, '0, '0, 1'b0, '0, k);
        check("commit_nonbusy_stays0", 32'(rfa_ps_busy[9]), 32'(0));

        // Reset landing on a MUL grant cycle.
        step(1'b1, 3'b000, '0, '0, 1'b0, '0, k);
        a[0] = 4'd1;
        step(1'b0, 3'b001, a, d, 1'b1, 4'd2, k);
        a[1] = 4'd9;
        step(1'b1, 3'b010, a, d, 1'b1, 4'd4, k);
        check("reset_gnt_forced_low", 32'(dut_gnt), 32'(0));
        step(1'b0, 3'b000, '0, '0, 1'b0, '0, k);
        check("reset_no_write", 32'(xb_rf_w_En), 32'(0));
        check("reset_busy_clear", 32'(rfa_ps_busy), 32'(0));
        step(1'b0, 3'b111, a, d, 1'b0, '0, k);
        check("reset_ptr_alu", 32'(dut_gnt), 32'(3'b001));
        idle(1);

        // Random traffic; a requester holds its request until granted.
        pr = '0;
        gl = -1;
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < 3; j++) begin
                if (!pr[j] || gl == j) begin
                    pr[j] = ($urandom_range(0, 99) < 55);
                    a[j]  = AW'($urandom);
                    d[j]  = DW'($urandom);
                end
            end
            rst  = ($urandom_range(0, 199) == 0);
            ren  = ($urandom_range(0, 2) == 0);
            radd = AW'($urandom);
            step(rst, pr, a, d, ren, radd, k);
            gl = k;
        end
        idle(3);
        check("queue_drained", 32'(exq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
